// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: scans a ROWS x COLS active-low key matrix and debounces the
// resolved key over whole scan frames. Press/release events are queued in a FIFO
// that the CPU reads through a CS/Addr/DataOut peripheral port.
// Optional feature macro: KEYPAD_IRQ_EN adds a registered irq output (STATUS[2]).
module keypad_scan_fifo #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            CS,
  input  logic [11:0]     Addr,
  output logic [31:0]     DataOut,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n
`ifdef KEYPAD_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned DebW = $clog2(DEBOUNCE + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Scan state
  logic [RowW-1:0] row_q, row_d;
  logic [DivW-1:0] div_q, div_d;
  logic [ROWS-1:0] row_n_q, row_n_d;
  logic            last_div, last_row, frame_end;

  // Per-row and per-frame key resolution
  logic            row_hit;
  logic [5:0]      row_code;
  logic            frame_vld_q, frame_vld_d;
  logic [5:0]      frame_code_q, frame_code_d;
  logic            res_vld;
  logic [5:0]      res_code;

  // Debounce state
  logic            cand_vld_q;
  logic [5:0]      cand_code_q;
  logic [DebW-1:0] cnt_q, cnt_next;
  logic            same_as_cand, differs_stable, accept;
  logic            stable_vld_q, stable_vld_d;
  logic [5:0]      stable_code_q, stable_code_d;

  // Second half of a K -> J change, pushed the cycle after the release
  logic            pend_vld_q, pend_vld_d;
  logic [5:0]      pend_code_q, pend_code_d;

  // Event FIFO
  logic            push_vld;
  logic [9:0]      push_data;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full, pop, do_push, drop;

  // Peripheral port
  logic            rd_event, rd_status;
  logic [31:0]     data_q, data_d;
  logic            irq_bit;
  logic            unused_addr;

  assign unused_addr = ^Addr[11:4];

`ifdef KEYPAD_IRQ_EN
  logic irq_q;
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign row_n   = row_n_q;
  assign DataOut = data_q;

  // Row and divider sequencing; row_n is registered so it tracks row_q exactly
  always_comb begin
    last_div  = (div_q == DivW'(SCAN_DIV - 1));
    last_row  = (row_q == RowW'(ROWS - 1));
    frame_end = last_div && last_row;
    div_d     = last_div ? '0 : div_q + DivW'(1);
    row_d     = row_q;
    if (last_div) begin
      row_d = last_row ? '0 : row_q + RowW'(1);
    end
    row_n_d = ~(ROWS'(1) << row_d);
  end

  // Lowest active column of the driven row
  always_comb begin
    row_hit  = 1'b0;
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_n[c]) begin
        row_hit  = 1'b1;
        row_code = 6'(row_q) * 6'(COLS) + 6'(c);
      end
    end
  end

  // Frame accumulation and debounce match counting
  always_comb begin
    frame_vld_d  = frame_vld_q;
    frame_code_d = frame_code_q;
    if (last_div) begin
      if (last_row) begin
        frame_vld_d  = 1'b0;
        frame_code_d = '0;
      end else if (!frame_vld_q && row_hit) begin
        frame_vld_d  = 1'b1;
        frame_code_d = row_code;
      end
    end
    // Earlier rows always carry lower codes, so an earlier hit wins
    res_vld  = frame_vld_q || row_hit;
    res_code = frame_vld_q ? frame_code_q : (row_hit ? row_code : 6'd0);

    same_as_cand = (res_vld == cand_vld_q) && (!res_vld || (res_code == cand_code_q));
    if (same_as_cand) begin
      cnt_next = (cnt_q == DebW'(DEBOUNCE)) ? cnt_q : cnt_q + DebW'(1);
    end else begin
      cnt_next = DebW'(1);
    end
    differs_stable = (res_vld != stable_vld_q) || (res_vld && (res_code != stable_code_q));
    accept         = frame_end && (cnt_next == DebW'(DEBOUNCE)) && differs_stable;
  end

  // Event generation on an accepted stable-state change
  always_comb begin
    push_vld      = pend_vld_q;
    push_data     = {2'b01, 2'b00, pend_code_q};
    pend_vld_d    = 1'b0;
    pend_code_d   = pend_code_q;
    stable_vld_d  = stable_vld_q;
    stable_code_d = stable_code_q;
    if (accept) begin
      stable_vld_d  = res_vld;
      stable_code_d = res_code;
      push_vld      = 1'b1;
      if (stable_vld_q) begin
        push_data   = {2'b11, 2'b00, stable_code_q};
        pend_vld_d  = res_vld;
        pend_code_d = res_code;
      end else begin
        push_data = {2'b01, 2'b00, res_code};
      end
    end
  end

  // FIFO control and register read decode
  always_comb begin
    rd_event  = CS && (Addr[3:0] == 4'h0);
    rd_status = CS && (Addr[3:0] == 4'h4);
    full      = (count_q == CntW'(FIFO_DEPTH));
    pop       = rd_event && (count_q != '0);
    // A pop frees the slot the same-cycle push lands in
    do_push   = push_vld && (!full || pop);
    drop      = push_vld && full && !pop;

    count_d = count_q;
    if (do_push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && pop) begin
      count_d = count_q - CntW'(1);
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (rd_status) begin
      ovf_d = 1'b0;
    end

    data_d = '0;
    if (CS) begin
      case (Addr[3:0])
        4'h0:    data_d = (count_q != '0) ? {22'd0, mem_q[rd_ptr_q]} : 32'd0;
        4'h4:    data_d = {16'd0, 8'(count_q), 5'd0, irq_bit, ovf_q, stable_vld_q};
        4'h8:    data_d = {8'd0, 8'(ROWS), 8'(COLS), 8'(FIFO_DEPTH)};
        default: data_d = '0;
      endcase
    end
  end

  // Scan, frame and debounce registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q         <= '0;
      div_q         <= '0;
      row_n_q       <= '1;
      frame_vld_q   <= 1'b0;
      frame_code_q  <= '0;
      cand_vld_q    <= 1'b0;
      cand_code_q   <= '0;
      cnt_q         <= '0;
      stable_vld_q  <= 1'b0;
      stable_code_q <= '0;
      pend_vld_q    <= 1'b0;
      pend_code_q   <= '0;
    end else begin
      row_q         <= row_d;
      div_q         <= div_d;
      row_n_q       <= row_n_d;
      frame_vld_q   <= frame_vld_d;
      frame_code_q  <= frame_code_d;
      if (frame_end) begin
        cand_vld_q  <= res_vld;
        cand_code_q <= res_code;
        cnt_q       <= cnt_next;
      end
      stable_vld_q  <= stable_vld_d;
      stable_code_q <= stable_code_d;
      pend_vld_q    <= pend_vld_d;
      pend_code_q   <= pend_code_d;
    end
  end

  // FIFO storage; emptiness is tracked by count, so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, count and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Registered read data (and irq when enabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
`ifdef KEYPAD_IRQ_EN
      irq_q  <= 1'b0;
`endif
    end else begin
      data_q <= data_d;
`ifdef KEYPAD_IRQ_EN
      irq_q  <= (count_q != '0) || ovf_q;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: a key-matrix model drives col_n from row_n; a
// queue-based event model predicts read data, and a monitor checks each read.
module tb_keypad_scan_fifo;

  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLS       = 4;
  localparam int unsigned SCAN_DIV   = 16;
  localparam int unsigned DEBOUNCE   = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FRAME      = ROWS * SCAN_DIV;
  localparam int unsigned HOLD       = (DEBOUNCE + 2) * FRAME;
  localparam logic [ROWS-1:0] LastRowN = ~(ROWS'(1) << (ROWS - 1));

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            CS    = 1'b0;
  logic [11:0]     Addr  = '0;
  logic [31:0]     DataOut;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
`ifdef KEYPAD_IRQ_EN
  logic            irq;
`endif

  logic [63:0] keys = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Scoreboard and reference model
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [9:0]  m_fifo[$];
  int          m_stable = -1;
  bit          m_ovf    = 1'b0;
  logic        cs_q, cs_qq;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .CS     (CS),
    .Addr   (Addr),
    .DataOut(DataOut),
    .row_n  (row_n),
    .col_n  (col_n)
`ifdef KEYPAD_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  // Passive key matrix: a held key pulls its column low while its row is driven
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!row_n[r] && keys[r * COLS + c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one response per read strobe, DataOut returns to 0 afterwards
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q  <= 1'b0;
      cs_qq <= 1'b0;
    end else begin
      cs_q  <= CS;
      cs_qq <= cs_q;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cs_q) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", DataOut);
      end else begin
        check(name_q.pop_front(), DataOut, exp_q.pop_front());
      end
    end else if (rst_n && cs_qq) begin
      check("idle_zero", DataOut, 32'h0);
    end
  end

  function automatic int lowest(input logic [63:0] k);
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (k[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] status_word();
    logic irqb;
    irqb = 1'b0;
`ifdef KEYPAD_IRQ_EN
    irqb = (m_fifo.size() != 0) || m_ovf;
`endif
    return {16'h0, 8'(m_fifo.size()), 5'h0, irqb, m_ovf, (m_stable >= 0)};
  endfunction

  task automatic mpush(input logic [9:0] ev);
    if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(ev);
    else m_ovf = 1'b1;
  endtask

  // Key set is now stable long enough to be accepted: emit model events
  task automatic model_settle(input logic [63:0] mask);
    int res;
    res = lowest(mask);
    if (res != m_stable) begin
      if (m_stable >= 0) mpush({2'b11, 2'b00, 6'(m_stable)});
      if (res >= 0) mpush({2'b01, 2'b00, 6'(res)});
      m_stable = res;
    end
  endtask

  task automatic set_keys(input logic [63:0] mask);
    keys = mask;
    repeat (HOLD) @(negedge clk);
    model_settle(mask);
  endtask

  // Short disturbance (at most one frame long) that must not produce events
  task automatic glitch(input logic [63:0] mask, input int len);
    logic [63:0] old;
    old  = keys;
    keys = mask;
    repeat (len) @(negedge clk);
    keys = old;
    repeat (HOLD) @(negedge clk);
  endtask

  // Called on a negedge; strobes one read and queues its expected response
  task automatic rd(input logic [3:0] off, input string name);
    logic [31:0] e;
    case (off)
      4'h0: e = (m_fifo.size() != 0) ? {22'h0, m_fifo.pop_front()} : 32'h0;
      4'h4: begin
        e     = status_word();
        m_ovf = 1'b0;
      end
      4'h8: e = {8'h0, 8'(ROWS), 8'(COLS), 8'(FIFO_DEPTH)};
      default: e = 32'h0;
    endcase
    exp_q.push_back(e);
    name_q.push_back(name);
    CS   = 1'b1;
    Addr = {8'($urandom()), off};
    @(negedge clk);
    CS   = 1'b0;
    Addr = '0;
    @(negedge clk);
  endtask

  // Stops at the negedge inside the last cycle of a frame
  task automatic sync_frame_last();
    int run;
    bit ok;
    run = 0;
    ok  = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (row_n == LastRowN) run++;
      else run = 0;
      if (run == SCAN_DIV) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_sync: got no full last-row period expected one within %0d cycles",
               4 * FRAME);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("reset_dataout", DataOut, 32'h0);
    check("reset_row_n", 32'(row_n), 32'((1 << ROWS) - 1));
`ifdef KEYPAD_IRQ_EN
    check("reset_irq", 32'(irq), 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'h4, "status_after_reset");
    rd(4'h8, "config");

    // Press row1/col2, then pop it
    set_keys(64'h1 << 6);
`ifdef KEYPAD_IRQ_EN
    check("irq_after_push", 32'(irq), 32'h1);
`endif
    rd(4'h4, "status_press");
    rd(4'h0, "event_press6");
`ifdef KEYPAD_IRQ_EN
    check("irq_after_pop", 32'(irq), 32'h0);
`endif
    rd(4'h4, "status_after_pop");

    // Release, then a glitch that must be filtered
    set_keys(64'h0);
    rd(4'h0, "event_release6");
    glitch(64'h1 << 6, FRAME);
    rd(4'h4, "status_after_glitch");

    // Six events into a four-deep FIFO
    set_keys(64'h1 << 1);
    set_keys(64'h0);
    set_keys(64'h1 << 2);
    set_keys(64'h0);
    set_keys(64'h1 << 9);
    set_keys(64'h0);
    rd(4'h4, "status_overflow");
    rd(4'h4, "status_overflow_cleared");
    repeat (4) rd(4'h0, "drain_overflow");

    // Two keys: lowest code wins; empty read; K -> J change
    set_keys((64'h1 << 0) | (64'h1 << 5));
    rd(4'h0, "event_press0");
    rd(4'h0, "event_empty");
    rd(4'h4, "status_empty_held");
    set_keys(64'h1 << 5);
    rd(4'h0, "event_release0");
    rd(4'h0, "event_press5");
    set_keys(64'h0);
    rd(4'h0, "event_release5");

    // Full FIFO: pop and push land on the same edge
    set_keys(64'h1 << 1);
    set_keys(64'h0);
    set_keys(64'h1 << 2);
    set_keys(64'h0);
    sync_frame_last();
    @(posedge clk);
    #1 keys = 64'h1 << 3;
    repeat (DEBOUNCE) sync_frame_last();
    rd(4'h0, "event_pop_push_full");
    model_settle(64'h1 << 3);
    rd(4'h4, "status_pop_push_full");
    repeat (4) rd(4'h0, "drain_pop_push");
    set_keys(64'h0);
    rd(4'h0, "event_release3");

    // Randomised key activity with mixed reads
    for (int it = 0; it < 20; it++) begin
      logic [63:0] m;
      int          kind;
      m    = '0;
      kind = $urandom_range(0, 3);
      case (kind)
        0: set_keys(64'h0);
        1: begin
          m[$urandom_range(0, ROWS * COLS - 1)] = 1'b1;
          set_keys(m);
        end
        2: begin
          m[$urandom_range(0, ROWS * COLS - 1)] = 1'b1;
          m[$urandom_range(0, ROWS * COLS - 1)] = 1'b1;
          set_keys(m);
        end
        default: begin
          m[$urandom_range(0, ROWS * COLS - 1)] = 1'b1;
          glitch(m, $urandom_range(1, FRAME));
        end
      endcase
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        case ($urandom_range(0, 3))
          0: rd(4'h0, "rand_event");
          1: rd(4'h4, "rand_status");
          2: rd(4'h8, "rand_config");
          default: rd(4'($urandom_range(0, 15)), "rand_offset");
        endcase
      end
    end
    while (m_fifo.size() != 0) rd(4'h0, "rand_drain");
    rd(4'h4, "rand_final_status");

    // Reset in the middle of a read with three events queued
    set_keys(64'h0);
    set_keys(64'h1 << 1);
    set_keys(64'h0);
    set_keys(64'h1 << 2);
    keys = '0;
    CS   = 1'b1;
    Addr = 12'h004;
    @(posedge clk);
    #2;
    check("status_before_reset", DataOut, status_word());
    rst_n = 1'b0;
    #1;
    CS   = 1'b0;
    Addr = '0;
    check("midreset_dataout", DataOut, 32'h0);
    check("midreset_row_n", 32'(row_n), 32'((1 << ROWS) - 1));
`ifdef KEYPAD_IRQ_EN
    check("midreset_irq", 32'(irq), 32'h0);
`endif
    m_fifo.delete();
    m_stable = -1;
    m_ovf    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'h4, "status_after_midreset");
    rd(4'h0, "event_after_midreset");

    repeat (4) @(negedge clk);
    check("responses_outstanding", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
